forest_sample_sched: RTL and testbench
======================================

Name: forest_sample_sched

Overview:
- Sequencer for the sample FIFO in the inference datapath.
- Loads one batch of feature samples from the upstream stream into the FIFO, then replays the whole batch once per tree, rewinding with the FIFO's mark/read-reset mechanism.
- Delivers samples to the tree engine tagged with a tree index, absorbing the FIFO's 3-cycle read latency with an internal skid buffer.
- Sits between the sample ingest stream, sample_fifo and the tree-evaluation engine.

Parameters:
- FIFO_WIDTH, 16, sample word width (matches the FIFO).
- FIFO_DEPTH_BIT, 4, log2 of FIFO depth; maximum batch size is 2**FIFO_DEPTH_BIT-1.
- TREE_BIT, 4, width of the tree count and tree index.
- RD_LAT, 3, FIFO pop-to-o_vld latency.
- SKID_DEPTH, 4, output skid entries; must be >= RD_LAT+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_start  in  1  one-cycle pulse; starts a job (ignored unless IDLE)
- i_num_smp  in  FIFO_DEPTH_BIT  batch size N, 1..2**FIFO_DEPTH_BIT-1; sampled on i_start
- i_num_tree  in  TREE_BIT  tree count T, 1..2**TREE_BIT-1; sampled on i_start
- i_smp_data  in  FIFO_WIDTH  upstream sample
- i_smp_vld  in  1  upstream valid
- o_smp_rdy  out  1  upstream ready
- o_fifo_flush, o_fifo_read_rst, o_fifo_mark_read_rst, o_fifo_push, o_fifo_pop  out  1 each  FIFO controls
- o_fifo_rear  out  FIFO_WIDTH  FIFO write data
- i_fifo_full, i_fifo_empty, i_fifo_vld  in  1 each  FIFO status
- i_fifo_front  in  FIFO_WIDTH  FIFO read data
- o_dn_data  out  FIFO_WIDTH  sample to tree engine
- o_dn_tree  out  TREE_BIT  tree index of o_dn_data
- o_dn_last  out  1  last sample of the current tree pass
- o_dn_vld  out  1  downstream valid
- i_dn_rdy  in  1  downstream ready
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset: all outputs 0; state IDLE; skid buffer empty; all counters 0. Reset mid-job aborts without flushing the FIFO; the next job's FLUSH clears it.
- IDLE -> FLUSH on i_start; latch N and T.
- FLUSH: o_fifo_flush high for 1 cycle, then 2 settle cycles with no push or pop; -> LOAD.
- LOAD:
  - o_smp_rdy = !i_fifo_full && (load_cnt < N).
  - A transfer is i_smp_vld & o_smp_rdy; it drives o_fifo_push=1 and o_fifo_rear=i_smp_data in the same cycle.
  - load_cnt increments per transfer. When load_cnt reaches N, -> REPLAY with tree=0.
  - o_smp_rdy is 0 in every other state.
- REPLAY:
  - Pop condition: o_fifo_pop = !i_fifo_empty && pop_cnt < N && (skid_cnt + inflight) < SKID_DEPTH.
  - inflight counts pops not yet returned on i_fifo_vld. Each i_fifo_vld writes i_fifo_front into the skid buffer.
  - Tree 0 only: o_fifo_mark_read_rst pulses exactly once, in the cycle after the first pop, so the FIFO's mark (rptr-1) captures the batch start.
  - Skid head drives o_dn_data/o_dn_vld; it pops on i_dn_vld & i_dn_rdy. o_dn_tree is the current tree. o_dn_last=1 on the N-th delivered sample of the pass.
  - When the N-th sample is accepted downstream: if tree==T-1, -> DONE; else -> REWIND.
- REWIND: o_fifo_read_rst high for 1 cycle, then 2 settle cycles; tree++, pop_cnt=0, deliver_cnt=0; -> REPLAY.
- DONE: o_done=1 for 1 cycle; -> IDLE. The FIFO is left holding the batch.
- Downstream AXI-style rules: o_dn_data and o_dn_tree are stable while o_dn_vld && !i_dn_rdy; o_dn_vld has no dependency on i_dn_rdy.
- Simultaneous skid write and read in one cycle is legal; skid_cnt is unchanged. Skid occupancy never exceeds SKID_DEPTH.
- i_start while busy is ignored. i_num_smp=0 or i_num_tree=0 is illegal and treated as 1.
- Pointer wrap-around is handled inside the FIFO. Counters are sized so that N and T never overflow them.

Test Plan:
- N=5, T=1, upstream always valid, i_dn_rdy=1 -> 5 pushes with no gaps, then samples 0..4 delivered in order with tree=0; o_dn_last on sample 4; one o_done pulse.
- N=3, T=4 -> 12 deliveries, samples 0,1,2 repeated with tree=0..3; exactly 1 mark pulse and 3 read_rst pulses.
- N=15 (full depth), T=2, i_dn_rdy toggling 1-of-3 cycles -> no sample lost or duplicated; skid_cnt+inflight never exceeds 4; data held stable during stalls.
- Upstream i_smp_vld random 50% during LOAD -> exactly N pushes; o_smp_rdy=0 once load_cnt=N.
- rst_n low for 1 cycle mid-REPLAY, then a new job with N=2, T=2 -> outputs 0 after reset; new job flushes and delivers only the new data.
- i_start pulsed while busy -> ignored; the current job completes normally.

Source files
------------

// File: rtl/forest_sample_sched.sv
// forest_sample_sched: loads one sample batch into sample_fifo, then replays it once per
// tree through a small skid buffer that absorbs the FIFO read latency.
module forest_sample_sched #(
  parameter int FIFO_WIDTH     = 16,
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int TREE_BIT       = 4,
  parameter int RD_LAT         = 3,
  parameter int SKID_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [FIFO_DEPTH_BIT-1:0] i_num_smp,
  input  logic [TREE_BIT-1:0]       i_num_tree,
  input  logic [FIFO_WIDTH-1:0]     i_smp_data,
  input  logic                      i_smp_vld,
  output logic                      o_smp_rdy,
  output logic                      o_fifo_flush,
  output logic                      o_fifo_read_rst,
  output logic                      o_fifo_mark_read_rst,
  output logic                      o_fifo_push,
  output logic                      o_fifo_pop,
  output logic [FIFO_WIDTH-1:0]     o_fifo_rear,
  input  logic                      i_fifo_full,
  input  logic                      i_fifo_empty,
  input  logic                      i_fifo_vld,
  input  logic [FIFO_WIDTH-1:0]     i_fifo_front,
  output logic [FIFO_WIDTH-1:0]     o_dn_data,
  output logic [TREE_BIT-1:0]       o_dn_tree,
  output logic                      o_dn_last,
  output logic                      o_dn_vld,
  input  logic                      i_dn_rdy,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2:0]                o_dbg_state
);

  // Valid/ready (upstream and downstream): a beat moves on a rising edge where valid && ready;
  // valid never depends on ready, and data/tag hold while valid && !ready.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_LOAD   = 3'd2,
    S_REPLAY = 3'd3,
    S_REWIND = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int SKID_AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_W   = $clog2(SKID_DEPTH + 1);
  // At most one pop per cycle and each returns RD_LAT cycles later.
  localparam int INF_W   = $clog2(RD_LAT + 1);
  localparam logic [SKID_AW-1:0] SKID_LAST = SKID_AW'(SKID_DEPTH - 1);
  localparam logic [OCC_W:0]     SKID_LIM  = (OCC_W + 1)'(SKID_DEPTH);

  state_t                    r_state;
  logic [FIFO_DEPTH_BIT-1:0] r_num_smp;
  logic [FIFO_DEPTH_BIT-1:0] r_load_cnt;
  logic [FIFO_DEPTH_BIT-1:0] r_pop_cnt;
  logic [FIFO_DEPTH_BIT-1:0] r_dlv_cnt;
  logic [TREE_BIT-1:0]       r_num_tree;
  logic [TREE_BIT-1:0]       r_tree;
  logic [1:0]                r_settle;
  logic [INF_W-1:0]          r_inflight;
  logic [OCC_W-1:0]          r_skid_cnt;
  logic [SKID_AW-1:0]        r_skid_wp;
  logic [SKID_AW-1:0]        r_skid_rp;
  logic [FIFO_WIDTH-1:0]     r_skid_mem [SKID_DEPTH];
  logic                      r_fifo_flush;
  logic                      r_fifo_read_rst;
  logic                      r_fifo_mark;
  logic                      r_done;

  logic                      w_smp_rdy;
  logic                      w_push;
  logic [OCC_W:0]            w_occ;
  logic                      w_pop;
  logic                      w_skid_wr;
  logic                      w_dn_vld;
  logic                      w_dn_acc;
  logic                      w_pass_end;

  assign w_smp_rdy  = (r_state == S_LOAD) && !i_fifo_full && (r_load_cnt < r_num_smp);
  assign w_push     = w_smp_rdy && i_smp_vld;
  // Pops still in the FIFO pipeline reserve a skid slot, so returns never find it full.
  assign w_occ      = (OCC_W + 1)'(r_skid_cnt) + (OCC_W + 1)'(r_inflight);
  assign w_pop      = (r_state == S_REPLAY) && !i_fifo_empty && (r_pop_cnt < r_num_smp)
                      && (w_occ < SKID_LIM);
  assign w_skid_wr  = (r_state == S_REPLAY) && i_fifo_vld;
  assign w_dn_vld   = (r_state == S_REPLAY) && (r_skid_cnt != '0);
  assign w_dn_acc   = w_dn_vld && i_dn_rdy;
  assign w_pass_end = w_dn_acc && (r_dlv_cnt == r_num_smp - 1'b1);

  assign o_smp_rdy            = w_smp_rdy;
  assign o_fifo_push          = w_push;
  assign o_fifo_rear          = w_push ? i_smp_data : '0;
  assign o_fifo_pop           = w_pop;
  assign o_fifo_flush         = r_fifo_flush;
  assign o_fifo_read_rst      = r_fifo_read_rst;
  assign o_fifo_mark_read_rst = r_fifo_mark;
  assign o_dn_vld             = w_dn_vld;
  assign o_dn_data            = r_skid_mem[r_skid_rp];
  assign o_dn_tree            = r_tree;
  assign o_dn_last            = w_dn_vld && (r_dlv_cnt == r_num_smp - 1'b1);
  assign o_busy               = (r_state != S_IDLE);
  assign o_done               = r_done;
  assign o_dbg_state          = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_num_smp       <= '0;
      r_load_cnt      <= '0;
      r_pop_cnt       <= '0;
      r_dlv_cnt       <= '0;
      r_num_tree      <= '0;
      r_tree          <= '0;
      r_settle        <= '0;
      r_inflight      <= '0;
      r_skid_cnt      <= '0;
      r_skid_wp       <= '0;
      r_skid_rp       <= '0;
      r_fifo_flush    <= 1'b0;
      r_fifo_read_rst <= 1'b0;
      r_fifo_mark     <= 1'b0;
      r_done          <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) r_skid_mem[i] <= '0;
    end else begin
      r_fifo_flush    <= 1'b0;
      r_fifo_read_rst <= 1'b0;
      r_fifo_mark     <= 1'b0;
      r_done          <= 1'b0;

      // The cycle after the very first pop the FIFO's rptr-1 is the batch start.
      if (w_pop && (r_tree == '0) && (r_pop_cnt == '0)) r_fifo_mark <= 1'b1;

      case ({w_pop, w_skid_wr})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: ;
      endcase

      case ({w_skid_wr, w_dn_acc})
        2'b10:   r_skid_cnt <= r_skid_cnt + 1'b1;
        2'b01:   r_skid_cnt <= r_skid_cnt - 1'b1;
        default: ;
      endcase

      if (w_skid_wr) begin
        r_skid_mem[r_skid_wp] <= i_fifo_front;
        r_skid_wp             <= (r_skid_wp == SKID_LAST) ? '0 : r_skid_wp + 1'b1;
      end
      if (w_dn_acc) begin
        r_skid_rp <= (r_skid_rp == SKID_LAST) ? '0 : r_skid_rp + 1'b1;
        r_dlv_cnt <= r_dlv_cnt + 1'b1;
      end
      if (w_pop)  r_pop_cnt  <= r_pop_cnt + 1'b1;
      if (w_push) r_load_cnt <= r_load_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_smp    <= (i_num_smp == '0) ? FIFO_DEPTH_BIT'(1) : i_num_smp;
            r_num_tree   <= (i_num_tree == '0) ? TREE_BIT'(1) : i_num_tree;
            r_load_cnt   <= '0;
            r_pop_cnt    <= '0;
            r_dlv_cnt    <= '0;
            r_tree       <= '0;
            r_settle     <= '0;
            r_fifo_flush <= 1'b1;
            r_state      <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_settle <= r_settle + 1'b1;
          if (r_settle == 2'd2) begin
            r_settle <= '0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_push && (r_load_cnt + 1'b1 == r_num_smp)) begin
            r_tree    <= '0;
            r_pop_cnt <= '0;
            r_dlv_cnt <= '0;
            r_state   <= S_REPLAY;
          end
        end
        S_REPLAY: begin
          if (w_pass_end) begin
            if (r_tree == r_num_tree - 1'b1) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_fifo_read_rst <= 1'b1;
              r_settle        <= '0;
              r_state         <= S_REWIND;
            end
          end
        end
        S_REWIND: begin
          r_settle <= r_settle + 1'b1;
          if (r_settle == 2'd2) begin
            r_settle  <= '0;
            r_tree    <= r_tree + 1'b1;
            r_pop_cnt <= '0;
            r_dlv_cnt <= '0;
            r_state   <= S_REPLAY;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_forest_sample_sched.sv
// Table-driven bench for forest_sample_sched with a behavioural sample_fifo model
// (mark/read-reset, 3-cycle read latency) and an expected-sample queue.
module tb_forest_sample_sched;

  localparam int W      = 16;
  localparam int DB     = 4;
  localparam int TB     = 4;
  localparam int RD_LAT = 3;
  localparam int SKID   = 4;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [DB-1:0] i_num_smp = '0;
  logic [TB-1:0] i_num_tree = '0;
  logic [W-1:0]  i_smp_data = '0;
  logic          i_smp_vld = 1'b0;
  logic          i_dn_rdy = 1'b0;
  logic          o_smp_rdy, o_fifo_flush, o_fifo_read_rst, o_fifo_mark_read_rst;
  logic          o_fifo_push, o_fifo_pop;
  logic [W-1:0]  o_fifo_rear;
  logic          i_fifo_full, i_fifo_empty, i_fifo_vld;
  logic [W-1:0]  i_fifo_front;
  logic [W-1:0]  o_dn_data;
  logic [TB-1:0] o_dn_tree;
  logic          o_dn_last, o_dn_vld, o_busy, o_done;
  logic [2:0]    o_dbg_state;

  always #5 clk = ~clk;

  forest_sample_sched #(
    .FIFO_WIDTH(W), .FIFO_DEPTH_BIT(DB), .TREE_BIT(TB), .RD_LAT(RD_LAT), .SKID_DEPTH(SKID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_smp(i_num_smp),
    .i_num_tree(i_num_tree), .i_smp_data(i_smp_data), .i_smp_vld(i_smp_vld),
    .o_smp_rdy(o_smp_rdy), .o_fifo_flush(o_fifo_flush), .o_fifo_read_rst(o_fifo_read_rst),
    .o_fifo_mark_read_rst(o_fifo_mark_read_rst), .o_fifo_push(o_fifo_push),
    .o_fifo_pop(o_fifo_pop), .o_fifo_rear(o_fifo_rear), .i_fifo_full(i_fifo_full),
    .i_fifo_empty(i_fifo_empty), .i_fifo_vld(i_fifo_vld), .i_fifo_front(i_fifo_front),
    .o_dn_data(o_dn_data), .o_dn_tree(o_dn_tree), .o_dn_last(o_dn_last),
    .o_dn_vld(o_dn_vld), .i_dn_rdy(i_dn_rdy), .o_busy(o_busy), .o_done(o_done),
    .o_dbg_state(o_dbg_state)
  );

  // sample_fifo model: 16 slots (15 usable), mark = rptr-1, read_rst restores rptr from mark
  logic [W-1:0]      f_mem [16];
  logic [DB-1:0]     f_wptr = '0, f_rptr = '0, f_mark = '0;
  logic [DB-1:0]     f_cnt;
  logic [RD_LAT-1:0] f_vpipe = '0;
  logic [W-1:0]      f_dpipe [RD_LAT];

  assign f_cnt        = f_wptr - f_rptr;
  assign i_fifo_empty = (f_wptr == f_rptr);
  assign i_fifo_full  = (f_cnt == 4'd15);
  assign i_fifo_vld   = f_vpipe[RD_LAT-1];
  assign i_fifo_front = f_dpipe[RD_LAT-1];

  always @(posedge clk) begin
    if (o_fifo_flush) begin
      f_wptr <= '0;
      f_rptr <= '0;
    end else begin
      if (o_fifo_push) begin
        f_mem[f_wptr] <= o_fifo_rear;
        f_wptr        <= f_wptr + 1'b1;
      end
      if (o_fifo_read_rst) f_rptr <= f_mark;
      else if (o_fifo_pop) f_rptr <= f_rptr + 1'b1;
    end
    if (o_fifo_mark_read_rst) f_mark <= f_rptr - 1'b1;
    f_vpipe    <= {f_vpipe[RD_LAT-2:0], o_fifo_pop};
    f_dpipe[0] <= f_mem[f_rptr];
    for (int i = 1; i < RD_LAT; i++) f_dpipe[i] <= f_dpipe[i-1];
  end

  typedef struct {
    logic [DB-1:0] n;
    logic [TB-1:0] t;
    int en, et, rdy_mode, vld_mode;
    bit poke;
    int exp_deliv, exp_mark, exp_rrst, exp_push, exp_last;
  } vec_t;

  vec_t vecs [5];

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] exp_q[$];
  logic [19:0] held;
  logic [W-1:0] data_base;
  bit  stall_pend, done_seen, poke;
  int  cyc, exp_n, rdy_mode, vld_mode, up_idx;
  int  push_cnt, pop_cnt, deliv, mark_cnt, rrst_cnt, flush_cnt, done_cnt, last_cnt;
  int  first_push, last_push, rdy_err, push_err, pop_err, occ_err, stall_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setup_job(input int en, input int et, input logic [W-1:0] base);
    exp_q.delete();
    for (int tr = 0; tr < et; tr++)
      for (int i = 0; i < en; i++) exp_q.push_back({4'(tr), 16'(base + 16'(i))});
    exp_n = en; data_base = base; up_idx = 0; cyc = 0;
    push_cnt = 0; pop_cnt = 0; deliv = 0; mark_cnt = 0; rrst_cnt = 0; flush_cnt = 0;
    done_cnt = 0; last_cnt = 0; first_push = 0; last_push = 0;
    rdy_err = 0; push_err = 0; pop_err = 0; occ_err = 0; stall_err = 0;
    stall_pend = 1'b0; done_seen = 1'b0; held = '0;
  endtask

  task automatic step();
    logic exp_last;
    int   outstanding;
    @(negedge clk);
    cyc++;
    i_start = poke && (cyc == 20);
    if (poke && cyc == 20) begin
      i_num_smp  = 4'd9;
      i_num_tree = 4'd9;
    end
    i_dn_rdy   = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    i_smp_vld  = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    i_smp_data = data_base + W'(up_idx);
    #1;
    if (o_smp_rdy && push_cnt >= exp_n) rdy_err++;
    if (o_fifo_push !== (i_smp_vld && o_smp_rdy)) push_err++;
    if (o_fifo_push) begin
      if (o_fifo_rear !== i_smp_data) push_err++;
      if (push_cnt == 0) first_push = cyc;
      last_push = cyc;
      push_cnt++;
      up_idx++;
    end
    outstanding = pop_cnt - deliv;
    if (o_fifo_pop) begin
      if (i_fifo_empty) pop_err++;
      if (outstanding >= SKID) occ_err++;
      pop_cnt++;
    end
    if (o_fifo_mark_read_rst) mark_cnt++;
    if (o_fifo_read_rst) rrst_cnt++;
    if (o_fifo_flush) flush_cnt++;
    if (o_done) begin
      done_cnt++;
      done_seen = 1'b1;
    end
    if (stall_pend && (!o_dn_vld || {o_dn_tree, o_dn_data} !== held)) stall_err++;
    stall_pend = o_dn_vld && !i_dn_rdy;
    held = {o_dn_tree, o_dn_data};
    if (o_dn_vld && i_dn_rdy) begin
      exp_last = ((deliv % exp_n) == exp_n - 1);
      if (exp_q.size() == 0) chk("dn_extra", {o_dn_tree, o_dn_data}, 0);
      else chk("dn_sample", {o_dn_last, o_dn_tree, o_dn_data}, {exp_last, exp_q.pop_front()});
      if (o_dn_last) last_cnt++;
      deliv++;
    end
  endtask

  task automatic run_job(input vec_t v, input logic [W-1:0] base);
    int post;
    setup_job(v.en, v.et, base);
    rdy_mode = v.rdy_mode;
    vld_mode = v.vld_mode;
    poke     = v.poke;
    post     = 0;
    @(negedge clk);
    i_start    = 1'b1;
    i_num_smp  = v.n;
    i_num_tree = v.t;
    while (!(done_seen && post >= 4) && cyc < BUDGET) begin
      step();
      if (done_seen) post++;
    end
    chk("done_seen", done_seen, 1);
    chk("deliveries", deliv, v.exp_deliv);
    chk("mark_pulses", mark_cnt, v.exp_mark);
    chk("read_rst_pulses", rrst_cnt, v.exp_rrst);
    chk("pushes", push_cnt, v.exp_push);
    chk("last_flags", last_cnt, v.exp_last);
    chk("done_pulses", done_cnt, 1);
    chk("flush_pulses", flush_cnt, 1);
    chk("samples_left", exp_q.size(), 0);
    chk("rdy_after_load", rdy_err, 0);
    chk("push_protocol", push_err, 0);
    chk("pop_when_empty", pop_err, 0);
    chk("skid_occupancy", occ_err, 0);
    chk("dn_stall_hold", stall_err, 0);
    if (v.vld_mode == 0) chk("push_gapless", last_push - first_push, v.exp_push - 1);
    chk("busy_after_done", o_busy, 0);
  endtask

  initial begin
    //        n      t    en et rdy vld poke deliv mark rrst push last
    vecs[0] = '{4'd5,  4'd1, 5, 1, 0, 0, 1'b0, 5,  1, 0, 5,  1};
    vecs[1] = '{4'd3,  4'd4, 3, 4, 0, 0, 1'b1, 12, 1, 3, 3,  4};
    vecs[2] = '{4'd15, 4'd2, 15, 2, 1, 0, 1'b0, 30, 1, 1, 15, 2};
    vecs[3] = '{4'd7,  4'd3, 7, 3, 0, 1, 1'b0, 21, 1, 2, 7,  3};
    vecs[4] = '{4'd0,  4'd0, 1, 1, 1, 0, 1'b0, 1,  1, 0, 1,  1};

    i_smp_vld  = 1'b1;
    i_smp_data = 16'hFFFF;
    i_dn_rdy   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {o_smp_rdy, o_fifo_flush, o_fifo_read_rst, o_fifo_mark_read_rst,
                     o_fifo_push, o_fifo_pop, o_dn_last, o_dn_vld, o_busy, o_done}, 0);
    chk("rst_fifo_rear", o_fifo_rear, 0);
    chk("rst_dn_data", o_dn_data, 0);
    chk("rst_dn_tree", o_dn_tree, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_job(vecs[k], W'(16'h1000 * (k + 1)));

    // Abort a job mid-replay with a one-cycle reset, then check a fresh job sees only new data.
    setup_job(4, 3, 16'h7000);
    rdy_mode = 0;
    vld_mode = 0;
    poke     = 1'b0;
    @(negedge clk);
    i_start    = 1'b1;
    i_num_smp  = 4'd4;
    i_num_tree = 4'd3;
    while (deliv < 2 && cyc < BUDGET) step();
    chk("abort_in_replay", (deliv >= 2) && o_busy && !o_done, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_rst_ctrl", {o_smp_rdy, o_fifo_flush, o_fifo_read_rst, o_fifo_mark_read_rst,
                           o_fifo_push, o_fifo_pop, o_dn_last, o_dn_vld, o_busy, o_done}, 0);
    chk("abort_rst_dn_data", o_dn_data, 0);
    rst_n = 1'b1;
    run_job('{4'd2, 4'd2, 2, 2, 0, 0, 1'b0, 4, 1, 1, 2, 2}, 16'h9000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
